// File: rtl/axil_adder_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite multi-channel adder.
package axil_adder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register offsets are word indices inside a channel's 16-byte window (address bits [3:2])
  localparam logic [1:0] OFF_OPA  = 2'd0;
  localparam logic [1:0] OFF_OPB  = 2'd1;
  localparam logic [1:0] OFF_SUM  = 2'd2;
  localparam logic [1:0] OFF_STAT = 2'd3;

  localparam int STAT_CARRY = 0;
  localparam int STAT_VALID = 1;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_adder_channel.sv
// One adder channel: byte-strobed operand registers, registered sum, carry and sticky result_valid.
// Defining AXIL_ADDER_SAT_EN makes SUM saturate to all-ones on carry-out.
module axil_adder_channel #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_a,
  input  logic                    wr_b,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   op_a,
  output logic [DATA_WIDTH-1:0]   op_b,
  output logic [DATA_WIDTH-1:0]   sum,
  output logic                    carry,
  output logic                    result_valid
);

  logic [DATA_WIDTH-1:0] a_next;
  logic [DATA_WIDTH-1:0] b_next;
  logic [DATA_WIDTH-1:0] sum_next;
  logic [DATA_WIDTH:0]   full;

  // The sum is formed from the merged operands so SUM is already current when bvalid rises
  always_comb begin
    a_next = op_a;
    b_next = op_b;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (wr_a && wstrb[i]) a_next[8*i +: 8] = wdata[8*i +: 8];
      if (wr_b && wstrb[i]) b_next[8*i +: 8] = wdata[8*i +: 8];
    end
    full = {1'b0, a_next} + {1'b0, b_next};
`ifdef AXIL_ADDER_SAT_EN
    sum_next = full[DATA_WIDTH] ? '1 : full[DATA_WIDTH-1:0];
`else
    sum_next = full[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a         <= '0;
      op_b         <= '0;
      sum          <= '0;
      carry        <= 1'b0;
      result_valid <= 1'b0;
    end else if (wr_a || wr_b) begin
      op_a         <= a_next;
      op_b         <= b_next;
      sum          <= sum_next;
      carry        <= full[DATA_WIDTH];
      result_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/axil_multi_adder.sv
// AXI4-Lite slave exposing NUM_CH independent adder channels, each in a 16-byte window.
// Build with AXIL_ADDER_SAT_EN defined to make every channel's SUM saturate on carry.
module axil_multi_adder
  import axil_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] NUM_CH_A = ADDR_WIDTH'(NUM_CH);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;
  logic active;
  logic aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] awaddr_q, c_addr, w_chan, r_chan;
  logic [DATA_WIDTH-1:0] wdata_q, c_data, rdata_q, rd_val;
  logic [STRB_W-1:0]     wstrb_q, c_strb;
  logic [1:0]            w_off, r_off, bresp_q, rresp_q;
  logic                  w_ok, r_ok;
  logic [NUM_CH-1:0]     wr_a, wr_b, carry_arr, valid_arr;
  logic [DATA_WIDTH-1:0] op_a_arr [NUM_CH];
  logic [DATA_WIDTH-1:0] op_b_arr [NUM_CH];
  logic [DATA_WIDTH-1:0] sum_arr  [NUM_CH];
  logic                  unused_addr_lsbs;

  // Readies stay low until the first edge after reset release
  assign s1_axi_awready = active && (w_state == W_IDLE || w_state == W_HAVE_DATA);
  assign s1_axi_wready  = active && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
  assign s1_axi_bvalid  = (w_state == W_RESP);
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_arready = active && (r_state == R_IDLE);
  assign s1_axi_rvalid  = (r_state == R_DATA);
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;

  assign aw_hs = s1_axi_awvalid && s1_axi_awready;
  assign w_hs  = s1_axi_wvalid && s1_axi_wready;
  assign ar_hs = s1_axi_arvalid && s1_axi_arready;

  assign c_addr = (w_state == W_HAVE_ADDR) ? awaddr_q : s1_axi_awaddr;
  assign c_data = (w_state == W_HAVE_DATA) ? wdata_q  : s1_axi_wdata;
  assign c_strb = (w_state == W_HAVE_DATA) ? wstrb_q  : s1_axi_wstrb;
  assign w_chan = c_addr >> 4;
  assign w_off  = c_addr[3:2];
  assign w_ok   = (w_chan < NUM_CH_A) && (w_off == OFF_OPA || w_off == OFF_OPB);
  assign r_chan = s1_axi_araddr >> 4;
  assign r_off  = s1_axi_araddr[3:2];
  assign r_ok   = (r_chan < NUM_CH_A);
  assign unused_addr_lsbs = ^{c_addr[1:0], s1_axi_araddr[1:0]};

  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (aw_hs) begin
          w_next = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_next = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: if (w_hs) begin
        commit = 1'b1;
        w_next = W_RESP;
      end
      W_HAVE_DATA: if (aw_hs) begin
        commit = 1'b1;
        w_next = W_RESP;
      end
      W_RESP: if (s1_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (s1_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_chan == ADDR_WIDTH'(c)) begin
        case (r_off)
          OFF_OPA: rd_val = op_a_arr[c];
          OFF_OPB: rd_val = op_b_arr[c];
          OFF_SUM: rd_val = sum_arr[c];
          default: begin
            rd_val             = '0;
            rd_val[STAT_CARRY] = carry_arr[c];
            rd_val[STAT_VALID] = valid_arr[c];
          end
        endcase
      end
    end
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      active  <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      active  <= 1'b1;
    end
  end

  // Beats are captured independently so AW and W may arrive in either order
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) awaddr_q <= s1_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s1_axi_wdata;
        wstrb_q <= s1_axi_wstrb;
      end
      if (commit) bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        rdata_q <= r_ok ? rd_val : '0;
        rresp_q <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_a[c] = commit && w_ok && (w_chan == ADDR_WIDTH'(c)) && (w_off == OFF_OPA);
    assign wr_b[c] = commit && w_ok && (w_chan == ADDR_WIDTH'(c)) && (w_off == OFF_OPB);

    axil_adder_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
      .clk          (s1_axi_aclk),
      .rst_n        (s1_axi_aresetn),
      .wr_a         (wr_a[c]),
      .wr_b         (wr_b[c]),
      .wdata        (c_data),
      .wstrb        (c_strb),
      .op_a         (op_a_arr[c]),
      .op_b         (op_b_arr[c]),
      .sum          (sum_arr[c]),
      .carry        (carry_arr[c]),
      .result_valid (valid_arr[c])
    );
  end

endmodule

// File: tb/tb_axil_multi_adder.sv
// Self-checking bench for axil_multi_adder: directed vector table, ordering/stall/reset sequences, random traffic vs a register model.
module tb_axil_multi_adder;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] m_a [NCH];
  logic [31:0] m_b [NCH];
  bit          m_v [NCH];

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

`ifdef AXIL_ADDER_SAT_EN
  localparam logic [31:0] CH2_SUM = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CH2_SUM = 32'h0000_0000;
`endif

  axil_multi_adder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_CH(NCH)) dut (
    .s1_axi_aclk    (clk),
    .s1_axi_aresetn (aresetn),
    .s1_axi_awaddr  (awaddr),
    .s1_axi_awvalid (awvalid),
    .s1_axi_awready (awready),
    .s1_axi_wdata   (wdata),
    .s1_axi_wstrb   (wstrb),
    .s1_axi_wvalid  (wvalid),
    .s1_axi_wready  (wready),
    .s1_axi_bresp   (bresp),
    .s1_axi_bvalid  (bvalid),
    .s1_axi_bready  (bready),
    .s1_axi_araddr  (araddr),
    .s1_axi_arvalid (arvalid),
    .s1_axi_arready (arready),
    .s1_axi_rdata   (rdata),
    .s1_axi_rresp   (rresp),
    .s1_axi_rvalid  (rvalid),
    .s1_axi_rready  (rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Register model: channel state kept as plain operand values, sum derived on demand
  function automatic void modelReset();
    for (int c = 0; c < NCH; c++) begin
      m_a[c] = '0;
      m_b[c] = '0;
      m_v[c] = 1'b0;
    end
  endfunction

  function automatic logic [1:0] modelWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int ch  = int'(addr) / 16;
    int off = (int'(addr) % 16) / 4;
    if (ch >= NCH || off > 1) return 2'b10;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        if (off == 0) m_a[ch][8*i +: 8] = data[8*i +: 8];
        else          m_b[ch][8*i +: 8] = data[8*i +: 8];
      end
    end
    m_v[ch] = 1'b1;
    return 2'b00;
  endfunction

  function automatic logic [31:0] modelReadData(input logic [7:0] addr);
    int ch  = int'(addr) / 16;
    int off = (int'(addr) % 16) / 4;
    longint full;
    bit carry;
    if (ch >= NCH) return 32'h0;
    full  = longint'(m_a[ch]) + longint'(m_b[ch]);
    carry = (full >= 64'h1_0000_0000);
    case (off)
      0: return m_a[ch];
      1: return m_b[ch];
      2: begin
`ifdef AXIL_ADDER_SAT_EN
        if (carry) return 32'hFFFF_FFFF;
`endif
        return 32'(full % 64'h1_0000_0000);
      end
      default: return {30'b0, m_v[ch], carry};
    endcase
  endfunction

  function automatic logic [1:0] modelReadResp(input logic [7:0] addr);
    return (int'(addr) / 16 >= NCH) ? 2'b10 : 2'b00;
  endfunction

  task automatic writeReg(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int stall,
                          output logic [1:0] resp, output int lat);
    int aw_beat, w_beat, last_beat;
    bit aw_ok, w_ok, seen, hold_bad;
    aw_beat = 0; w_beat = 0; aw_ok = 0; w_ok = 0; seen = 0; hold_bad = 0;
    resp = 2'bxx; lat = -1;
    fork
      begin
        repeat (aw_dly) @(posedge clk);
        #1;
        awaddr  = addr;
        awvalid = 1'b1;
        for (int i = 0; i < 40 && !aw_ok; i++) begin
          @(negedge clk);
          if (awready) begin aw_ok = 1; aw_beat = cyc; end
        end
        if (aw_ok) begin @(posedge clk); #1; end
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(posedge clk);
        #1;
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        for (int i = 0; i < 40 && !w_ok; i++) begin
          @(negedge clk);
          if (wready) begin w_ok = 1; w_beat = cyc; end
        end
        if (w_ok) begin @(posedge clk); #1; end
        wvalid = 1'b0;
      end
    join
    if (!aw_ok) checkOutput("aw_handshake", 32'(aw_ok), 32'd1);
    if (!w_ok)  checkOutput("w_handshake", 32'(w_ok), 32'd1);
    if (aw_ok && w_ok) begin
      last_beat = (aw_beat > w_beat) ? aw_beat : w_beat;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (bvalid) begin seen = 1; lat = cyc - last_beat; end
      end
      if (!seen) checkOutput("bvalid_timeout", 32'(seen), 32'd1);
      else begin
        resp = bresp;
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          if (!bvalid || bresp !== resp) hold_bad = 1;
        end
        if (stall > 0) checkOutput("bvalid_hold", 32'(hold_bad), 32'd0);
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
      end
    end
  endtask

  task automatic readReg(input logic [7:0] addr, input int stall,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int ar_beat;
    bit ar_ok, seen, hold_bad;
    ar_beat = 0; ar_ok = 0; seen = 0; hold_bad = 0;
    data = 'x; resp = 2'bxx; lat = -1;
    #1;
    araddr  = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 40 && !ar_ok; i++) begin
      @(negedge clk);
      if (arready) begin ar_ok = 1; ar_beat = cyc; end
    end
    if (ar_ok) begin @(posedge clk); #1; end
    arvalid = 1'b0;
    if (!ar_ok) checkOutput("ar_handshake", 32'(ar_ok), 32'd1);
    else begin
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (rvalid) begin seen = 1; lat = cyc - ar_beat; data = rdata; resp = rresp; end
      end
      if (!seen) checkOutput("rvalid_timeout", 32'(seen), 32'd1);
      else begin
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          if (!rvalid || rdata !== data || rresp !== resp) hold_bad = 1;
        end
        if (stall > 0) checkOutput("rvalid_hold", 32'(hold_bad), 32'd0);
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [1:0]  resp;
    logic [31:0] data;
    int lat;
    if (v.is_wr) begin
      writeReg(v.addr, v.data, v.strb, 0, 0, 0, resp, lat);
      void'(modelWrite(v.addr, v.data, v.strb));
      checkOutput($sformatf("vec%0d_bresp", idx), 32'(resp), 32'(v.exp_resp));
    end else begin
      readReg(v.addr, 0, data, resp, lat);
      checkOutput($sformatf("vec%0d_rdata", idx), data, v.exp_data);
      checkOutput($sformatf("vec%0d_rresp", idx), 32'(resp), 32'(v.exp_resp));
      checkOutput($sformatf("vec%0d_rlat", idx), 32'(lat), 32'd1);
    end
  endtask

  initial begin
    vec_t vecs [22];
    logic [1:0]  resp, exp_resp;
    logic [31:0] data, exp_data;
    int lat, lat_r;

    vecs[0]  = '{1'b1, 8'h00, 32'd39,         4'hF, 32'h0,         2'b00};
    vecs[1]  = '{1'b1, 8'h04, 32'd40,         4'hF, 32'h0,         2'b00};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,          4'h0, 32'd79,        2'b00};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,          4'h0, 32'h2,         2'b00};
    vecs[4]  = '{1'b1, 8'h20, 32'hFFFF_FFFF,  4'hF, 32'h0,         2'b00};
    vecs[5]  = '{1'b1, 8'h24, 32'h1,          4'hF, 32'h0,         2'b00};
    vecs[6]  = '{1'b0, 8'h28, 32'h0,          4'h0, CH2_SUM,       2'b00};
    vecs[7]  = '{1'b0, 8'h2C, 32'h0,          4'h0, 32'h3,         2'b00};
    vecs[8]  = '{1'b1, 8'h10, 32'h1234_5678,  4'hF, 32'h0,         2'b00};
    vecs[9]  = '{1'b1, 8'h10, 32'h0000_00AB,  4'h1, 32'h0,         2'b00};
    vecs[10] = '{1'b0, 8'h10, 32'h0,          4'h0, 32'h1234_56AB, 2'b00};
    vecs[11] = '{1'b1, 8'h08, 32'hDEAD_BEEF,  4'hF, 32'h0,         2'b10};
    vecs[12] = '{1'b0, 8'h08, 32'h0,          4'h0, 32'd79,        2'b00};
    vecs[13] = '{1'b0, 8'h0C, 32'h0,          4'h0, 32'h2,         2'b00};
    vecs[14] = '{1'b0, 8'h40, 32'h0,          4'h0, 32'h0,         2'b10};
    vecs[15] = '{1'b0, 8'h1C, 32'h0,          4'h0, 32'h2,         2'b00};
    vecs[16] = '{1'b1, 8'h3C, 32'h5,          4'hF, 32'h0,         2'b10};
    vecs[17] = '{1'b0, 8'h3C, 32'h0,          4'h0, 32'h0,         2'b00};
    vecs[18] = '{1'b0, 8'h30, 32'h0,          4'h0, 32'h0,         2'b00};
    vecs[19] = '{1'b1, 8'h14, 32'h2,          4'h0, 32'h0,         2'b00};
    vecs[20] = '{1'b0, 8'h1B, 32'h0,          4'h0, 32'h1234_56AB, 2'b00};
    vecs[21] = '{1'b0, 8'hF0, 32'h0,          4'h0, 32'h0,         2'b10};

    aresetn = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("reset_readies", {29'b0, awready, wready, arready}, 32'h0);
    checkOutput("reset_valids", {30'b0, bvalid, rvalid}, 32'h0);
    checkOutput("reset_resps", {28'b0, bresp, rresp}, 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 22; i++) applyStimulus(vecs[i], i);

    $display("[TB] AW/W ordering");
    for (int k = 0; k < 3; k++) begin
      int aw_d, w_d;
      aw_d = (k == 0) ? 2 : 0;
      w_d  = (k == 2) ? 2 : 0;
      data = 32'h100 * (k + 1);
      writeReg(8'h14, data, 4'hF, aw_d, w_d, 0, resp, lat);
      exp_resp = modelWrite(8'h14, data, 4'hF);
      checkOutput($sformatf("order%0d_bresp", k), 32'(resp), 32'(exp_resp));
      checkOutput($sformatf("order%0d_blat", k), 32'(lat), 32'd1);
      readReg(8'h18, 0, data, resp, lat_r);
      checkOutput($sformatf("order%0d_sum", k), data, modelReadData(8'h18));
    end

    $display("[TB] response back-pressure");
    writeReg(8'h00, 32'h55, 4'hF, 0, 0, 5, resp, lat);
    exp_resp = modelWrite(8'h00, 32'h55, 4'hF);
    checkOutput("stall_bresp", 32'(resp), 32'(exp_resp));
    readReg(8'h08, 5, data, resp, lat);
    checkOutput("stall_rdata", data, modelReadData(8'h08));

    $display("[TB] simultaneous read and write on one channel");
    exp_data = modelReadData(8'h08);
    fork
      writeReg(8'h00, 32'h1000, 4'hF, 0, 0, 0, resp, lat);
      readReg(8'h08, 0, data, exp_resp, lat_r);
    join
    checkOutput("simul_read_old", data, exp_data);
    void'(modelWrite(8'h00, 32'h1000, 4'hF));
    readReg(8'h08, 0, data, resp, lat_r);
    checkOutput("simul_read_new", data, modelReadData(8'h08));

    $display("[TB] random traffic");
    for (int n = 0; n < 60; n++) begin
      int ch, off;
      logic [7:0]  addr;
      logic [31:0] rnd;
      logic [3:0]  strb;
      ch   = $urandom_range(0, 5);
      off  = $urandom_range(0, 3);
      addr = 8'(ch * 16 + off * 4 + int'($urandom_range(0, 3)));
      rnd  = $urandom;
      strb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        writeReg(addr, rnd, strb, $urandom_range(0, 2), $urandom_range(0, 2), 0, resp, lat);
        exp_resp = modelWrite(addr, rnd, strb);
        checkOutput($sformatf("rand%0d_bresp@%02h", n, addr), 32'(resp), 32'(exp_resp));
        checkOutput($sformatf("rand%0d_blat", n), 32'(lat), 32'd1);
      end else begin
        readReg(addr, 0, data, resp, lat);
        checkOutput($sformatf("rand%0d_rdata@%02h", n, addr), data, modelReadData(addr));
        checkOutput($sformatf("rand%0d_rresp@%02h", n, addr), 32'(resp), 32'(modelReadResp(addr)));
      end
    end

    $display("[TB] asynchronous reset during a write");
    awaddr = 8'h14; awvalid = 1'b1;
    wdata = 32'hCAFE; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_bvalid", 32'(bvalid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("async_reset_outs",
                {22'b0, awready, wready, bvalid, bresp, arready, rvalid, rresp, 1'b0}, 32'h0);
    checkOutput("async_reset_rdata", rdata, 32'h0);
    modelReset();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    readReg(8'h14, 0, data, resp, lat);
    checkOutput("post_reset_opb", data, 32'h0);
    readReg(8'h1C, 0, data, resp, lat);
    checkOutput("post_reset_status", data, 32'h0);
    writeReg(8'h00, 32'd7, 4'hF, 0, 0, 0, resp, lat);
    void'(modelWrite(8'h00, 32'd7, 4'hF));
    readReg(8'h0C, 0, data, resp, lat);
    checkOutput("post_reset_valid", data, modelReadData(8'h0C));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
